// File: rtl/axi_lite_ram.sv
// rtl/axi_lite_ram.sv - AXI4-Lite responder backed by a word-addressed synchronous RAM
module axi_lite_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;

  logic [31:0] mem [DEPTH];

  rstate_t rstate, rstate_nxt;
  wstate_t wstate, wstate_nxt;

  logic                  aw_ready_q, w_ready_q;
  logic [DEPTH_LOG2-1:0] widx_q;
  logic                  w_oor_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q, bresp_q;

  logic                  ar_hs, aw_hs, w_hs, ar_oor, aw_oor;
  logic [DEPTH_LOG2-1:0] ar_idx;
  logic                  unused_addr_lsbs;

  assign ar_hs  = axi_arvalid & axi_arready;
  assign aw_hs  = axi_awvalid & aw_ready_q;
  assign w_hs   = axi_wvalid & w_ready_q;
  assign ar_oor = |axi_araddr[31:DEPTH_LOG2+2];
  assign aw_oor = |axi_awaddr[31:DEPTH_LOG2+2];
  assign ar_idx = axi_araddr[DEPTH_LOG2+1:2];
  assign unused_addr_lsbs = ^{axi_araddr[1:0], axi_awaddr[1:0]};

  assign axi_arready = (rstate == R_IDLE);
  assign axi_rvalid  = (rstate == R_DATA);
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_awready = aw_ready_q;
  assign axi_wready  = w_ready_q;
  assign axi_bvalid  = (wstate == W_RESP);
  assign axi_bresp   = bresp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstate <= R_IDLE;
      wstate <= W_IDLE;
    end else begin
      rstate <= rstate_nxt;
      wstate <= wstate_nxt;
    end
  end

  // A channel whose ready has dropped is already latched for this transaction.
  always_comb begin
    rstate_nxt = rstate;
    wstate_nxt = wstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_DATA;
      R_DATA:  if (axi_rready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
    case (wstate)
      W_IDLE:   if ((aw_hs | !aw_ready_q) & (w_hs | !w_ready_q)) wstate_nxt = W_COMMIT;
      W_COMMIT: wstate_nxt = W_RESP;
      W_RESP:   if (axi_bready) wstate_nxt = W_IDLE;
      default:  wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      widx_q     <= '0;
      w_oor_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= 2'b00;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      if (aw_hs) begin
        widx_q     <= axi_awaddr[DEPTH_LOG2+1:2];
        w_oor_q    <= aw_oor;
        aw_ready_q <= 1'b0;
      end
      if (w_hs) begin
        wdata_q   <= axi_wdata;
        wstrb_q   <= axi_wstrb;
        w_ready_q <= 1'b0;
      end
      if (wstate == W_COMMIT) bresp_q <= w_oor_q ? 2'b10 : 2'b00;
      if (wstate == W_RESP && axi_bready) begin
        aw_ready_q <= 1'b1;
        w_ready_q  <= 1'b1;
      end
      if (ar_hs) begin
        rdata_q <= ar_oor ? 32'h0 : mem[ar_idx];
        rresp_q <= ar_oor ? 2'b10 : 2'b00;
      end
    end
  end

  // RAM has no reset; a read on the commit edge sees the old word.
  always_ff @(posedge clk) begin
    if (wstate == W_COMMIT && !w_oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_ram.sv
// tb/tb_axi_lite_ram.sv - directed self-checking bench for axi_lite_ram
module tb_axi_lite_ram;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_rresp, axi_bresp;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [3:0]  axi_wstrb;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi_lite_ram #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input int rhold, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    axi_araddr  = a;
    axi_arvalid = 1'b1;
    while (!axi_arready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ar_wait", n < 50, 1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    check("rvalid_lat", axi_rvalid, 1);
    d = axi_rdata;
    r = axi_rresp;
    for (int i = 0; i < rhold; i++) begin
      @(posedge clk); #1;
      check("rhold_rvalid", axi_rvalid, 1);
      check("rhold_arready", axi_arready, 0);
      check("rhold_rdata", axi_rdata, d);
    end
    axi_rready = 1'b1;
    @(posedge clk); #1;
    axi_rready = 1'b0;
    check("rvalid_drop", axi_rvalid, 0);
    check("arready_rearm", axi_arready, 1);
  endtask

  // mode 0: AW and W together; 1: W one cycle before AW; 2: AW one cycle before W
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int mode, input int bhold, output logic [1:0] resp);
    check("wr_awready_idle", axi_awready, 1);
    check("wr_wready_idle", axi_wready, 1);
    axi_awaddr = a;
    axi_wdata  = d;
    axi_wstrb  = s;
    if (mode == 1) begin
      axi_wvalid = 1'b1;
      @(posedge clk); #1;
      axi_wvalid = 1'b0;
      check("wfirst_wready", axi_wready, 0);
      check("wfirst_awready", axi_awready, 1);
      axi_awvalid = 1'b1;
    end else if (mode == 2) begin
      axi_awvalid = 1'b1;
      @(posedge clk); #1;
      axi_awvalid = 1'b0;
      check("awfirst_awready", axi_awready, 0);
      check("awfirst_wready", axi_wready, 1);
      axi_wvalid = 1'b1;
    end else begin
      axi_awvalid = 1'b1;
      axi_wvalid  = 1'b1;
    end
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    check("bvalid_n1", axi_bvalid, 0);
    @(posedge clk); #1;
    check("bvalid_n2", axi_bvalid, 1);
    resp = axi_bresp;
    for (int i = 0; i < bhold; i++) begin
      @(posedge clk); #1;
      check("bhold_bvalid", axi_bvalid, 1);
      check("bhold_awready", axi_awready, 0);
      check("bhold_wready", axi_wready, 0);
      check("bhold_bresp", axi_bresp, resp);
    end
    axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b0;
    check("bvalid_drop", axi_bvalid, 0);
    check("awready_rearm", axi_awready, 1);
    check("wready_rearm", axi_wready, 1);
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    rstn = 1'b0;
    {axi_araddr, axi_awaddr, axi_wdata, axi_wstrb} = '0;
    {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", axi_arready, 1);
    check("rst_awready", axi_awready, 1);
    check("rst_wready", axi_wready, 1);
    check("rst_rvalid", axi_rvalid, 0);
    check("rst_bvalid", axi_bvalid, 0);
    check("rst_rdata", axi_rdata, 0);
    check("rst_rresp", axi_rresp, 0);
    check("rst_bresp", axi_bresp, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r);
    check("w10_bresp", r, 2'b00);
    rd(32'h10, 0, d, r);
    check("r10_data", d, 32'hDEADBEEF);
    check("r10_resp", r, 2'b00);

    wr(32'h10, 32'h11223344, 4'b0101, 1, 0, r);
    check("wstrb_bresp", r, 2'b00);
    rd(32'h10, 0, d, r);
    check("wstrb_data", d, 32'hDE22BE44);
    rd(32'h13, 0, d, r);
    check("lsb_ignored", d, 32'hDE22BE44);

    wr(32'h10, 32'hFFFFFFFF, 4'h0, 2, 0, r);
    check("strb0_bresp", r, 2'b00);
    rd(32'h10, 0, d, r);
    check("strb0_data", d, 32'hDE22BE44);

    wr(32'h0, 32'hA5A5A5A5, 4'hF, 0, 0, r);
    rd(32'h1000, 0, d, r);
    check("oor_rresp", r, 2'b10);
    check("oor_rdata", d, 32'h0);
    wr(32'h1000, 32'h12345678, 4'hF, 0, 0, r);
    check("oor_bresp", r, 2'b10);
    rd(32'h0, 0, d, r);
    check("oor_no_alias", d, 32'hA5A5A5A5);
    check("oor_ok_rresp", r, 2'b00);

    rd(32'h10, 5, d, r);
    check("rhold_value", d, 32'hDE22BE44);
    wr(32'h14, 32'hCAFEF00D, 4'hF, 0, 5, r);
    check("bhold_resp", r, 2'b00);
    rd(32'h14, 0, d, r);
    check("bhold_data", d, 32'hCAFEF00D);

    wr(32'h20, 32'h01020304, 4'hF, 0, 0, r);
    axi_awaddr = 32'h20; axi_wdata = 32'h55AA55AA; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    axi_araddr = 32'h20; axi_arvalid = 1'b1;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    check("race_rvalid", axi_rvalid, 1);
    check("race_old", axi_rdata, 32'h01020304);
    check("race_bvalid", axi_bvalid, 1);
    axi_rready = 1'b1; axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_rready = 1'b0; axi_bready = 1'b0;
    rd(32'h20, 0, d, r);
    check("race_new", d, 32'h55AA55AA);

    wr(32'h30, 32'h0BADF00D, 4'hF, 0, 0, r);
    axi_awaddr = 32'h30; axi_awvalid = 1'b1;
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    check("midrst_aw_latched", axi_awready, 0);
    rstn = 1'b0;
    #2;
    check("midrst_async_awready", axi_awready, 1);
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("midrst_awready", axi_awready, 1);
    check("midrst_wready", axi_wready, 1);
    check("midrst_bvalid", axi_bvalid, 0);
    axi_wdata = 32'hFFFFFFFF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    @(posedge clk); #1;
    axi_wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_commit", axi_bvalid, 0);
    axi_awaddr = 32'h34; axi_awvalid = 1'b1;
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    @(posedge clk); #1;
    check("midrst_w_then_aw", axi_bvalid, 1);
    axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b0;
    rd(32'h30, 0, d, r);
    check("midrst_word", d, 32'h0BADF00D);
    rd(32'h34, 0, d, r);
    check("midrst_late_w", d, 32'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/axi_lite_ram.md
AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, log2 of RAM depth in 32-bit words (1024 words, 4 KiB).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all state changes on posedge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 axi_araddr  in  32  read byte address.
REQ-006 axi_arvalid  in  1 / axi_arready  out  1  read address handshake.
REQ-007 axi_rdata  out  32 / axi_rresp  out  2 / axi_rvalid  out  1 / axi_rready  in  1  read data channel.
REQ-008 axi_awaddr  in  32 / axi_awvalid  in  1 / axi_awready  out  1  write address channel.
REQ-009 axi_wdata  in  32 / axi_wstrb  in  4 / axi_wvalid  in  1 / axi_wready  out  1  write data channel.
REQ-010 axi_bresp  out  2 / axi_bvalid  out  1 / axi_bready  in  1  write response channel.

Function
REQ-011 Block SHALL be an AXI4-Lite responder backed by 2^DEPTH_LOG2 x 32-bit synchronous RAM.
REQ-012 Word index SHALL be addr[DEPTH_LOG2+1:2]; addr[1:0] ignored.
REQ-013 Address with any of addr[31:DEPTH_LOG2+2] set SHALL be out of range: resp 2'b10 (SLVERR), no RAM write, rdata 0.
REQ-014 In-range accesses SHALL return resp 2'b00.
REQ-015 Read FSM states: R_IDLE (arready=1, rvalid=0), R_DATA (arready=0, rvalid=1).
REQ-016 R_IDLE->R_DATA on arvalid&arready at edge N; rvalid and rdata valid from cycle N+1 (1-cycle latency).
REQ-017 In R_DATA, rdata/rresp SHALL hold stable until rvalid&rready; that edge -> R_IDLE, arready=1 next cycle.
REQ-018 Write FSM states: W_IDLE (collecting), W_COMMIT, W_RESP (bvalid=1).
REQ-019 In W_IDLE, awready and wready SHALL each drop independently after their own handshake; the address or data SHALL be latched.
REQ-020 AW and W SHALL be accepted in any order or in the same cycle; once both are latched, the next state is W_COMMIT.
REQ-021 W_COMMIT SHALL write the RAM bytes whose wstrb bit is set (bit i -> byte [8i+7:8i]) and SHALL set bvalid/bresp; next state W_RESP.
REQ-022 If AW and W are accepted at edge N, the RAM update SHALL occur at edge N+1 and bvalid SHALL be high from cycle N+2.
REQ-023 wstrb=4'b0000 SHALL complete with OKAY and leave the RAM unchanged.
REQ-024 In W_RESP, bvalid/bresp SHALL hold until bready; at that edge bvalid=0, awready=wready=1, next state W_IDLE.
REQ-025 Read and write FSMs SHALL run concurrently and independently.
REQ-026 A read sampled at the same edge as a commit to the same word SHALL return the pre-write data.
REQ-027 No combinational path from any input to any output; all outputs registered.

Reset
REQ-028 On rstn=0: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; both FSMs to idle.
REQ-029 Reset mid-transaction SHALL discard pending latched AW/W without writing RAM and drop any rvalid/bvalid.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-031 Write 0x0000_0010 data 0xDEADBEEF strb 4'hF, AW/W same cycle -> bvalid at N+2, bresp 00; read 0x10 -> rdata 0xDEADBEEF at N+1, rresp 00.
REQ-032 W one cycle before AW, addr 0x10 data 0x11223344 strb 4'b0101 -> word 0x10 reads 0xDE22BE44.
REQ-033 Read 0x0000_1000 (out of range for DEPTH_LOG2=10) -> rresp 10, rdata 0; write there -> bresp 10, RAM unchanged.
REQ-034 Hold rready=0 for 5 cycles after rvalid -> rdata stable, arready=0 throughout; bready=0 likewise holds bvalid and blocks the next AW/W.
REQ-035 Concurrent write 0x55AA55AA to 0x20 and read 0x20 sampled on the commit edge -> read returns old value; next read returns 0x55AA55AA.
REQ-036 Assert rstn=0 after AW accepted, before W -> after reset awready=1, bvalid=0, word unchanged.
